// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the SPI mode-0 byte slave
//
// Contents:
//   SPI_DATA_W   default word width
//   spi_state_e  frame state (IDLE / ACTIVE)
//   clog2()      width helper for the bit counter
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // Ceiling log2; used only at elaboration time to size the bit counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - pin synchroniser with rise/fall strobes
//
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   d_i      asynchronous pin
//   level_o  synchronised level (SYNC_STAGES flops deep)
//   rise_o   one-cycle strobe: level_o went 0 -> 1
//   fall_o   one-cycle strobe: level_o went 1 -> 0
//
// RESET_VAL is the level every flop (including the edge-detect copy) holds
// in reset, so a pin idling at that level produces no strobe on release.
// SYNC_STAGES must be at least 2.
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_byte_if.sv
// rtl/spi_slave_byte_if.sv - SPI mode-0 slave, oversampled in the CLK_50 domain
//
// Ports:
//   CLK_50        system clock (only clock)
//   rst           synchronous active-high reset
//   CS            chip select pin, active low
//   SPI_CLK       SPI clock pin, idle low
//   SPI_incoming  MOSI pin
//   SPI_outgoing  MISO, registered
//   rx_data       last complete received word
//   rx_valid      one-cycle strobe, rx_data updated
//   tx_data       word offered for transmit
//   tx_valid      tx_data offered
//   tx_ready      transmit buffer empty
//   frame_active  frame in progress
//   frame_abort   one-cycle strobe, CS rose mid-word
//   tx_underrun   one-cycle strobe, shifter loaded from an empty buffer
//
// Received bits are sampled on the synchronised SCLK rising edge; transmit
// bits advance on the falling edge. A word boundary (bit counter at 0) on a
// falling edge, or the start of a frame, reloads the transmit shifter from
// the single-entry buffer.
module spi_slave_byte_if
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK_50,
  input  logic              rst,
  input  logic              CS,
  input  logic              SPI_CLK,
  input  logic              SPI_incoming,
  output logic              SPI_outgoing,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_active,
  output logic              frame_abort,
  output logic              tx_underrun
);

  localparam int                CNT_W    = (clog2(DATA_W) > 0) ? clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  // ---------------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------------
  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sync_cs (
    .clk_i   (CLK_50),
    .rst_i   (rst),
    .d_i     (CS),
    .level_o (cs_s),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_sclk (
    .clk_i   (CLK_50),
    .rst_i   (rst),
    .d_i     (SPI_CLK),
    .level_o (sclk_s),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_mosi (
    .clk_i   (CLK_50),
    .rst_i   (rst),
    .d_i     (SPI_incoming),
    .level_o (mosi_s),
    .rise_o  (mosi_rise),
    .fall_o  (mosi_fall)
  );

  // Only the SCLK edges and the MOSI level are consumed.
  logic unused_sync;
  assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  spi_state_e             state_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [DATA_W-1:0]      rx_shift_q;
  logic [DATA_W-1:0]      tx_shift_q;
  logic [DATA_W-1:0]      buf_q;
  logic                   buf_full_q;
  logic [DATA_W-1:0]      rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_abort_q;
  logic                   tx_underrun_q;
  logic                   miso_q;
  logic                   armed_q;
  logic [SYNC_STAGES-1:0] settle_q;

  // The CS synchroniser comes out of reset holding 1s, not pin samples.
  // settle_q fills with 1s as those reset values are flushed, so armed_q
  // only reacts to a genuinely sampled CS-high level. This keeps a CS held
  // low through reset release from looking like a fresh falling edge.
  logic settled;
  assign settled = settle_q[SYNC_STAGES-1];

  logic start_frame;
  logic end_frame;
  logic word_load;
  logic do_load;
  logic tx_accept;

  always_comb begin
    start_frame = 1'b0;
    end_frame   = 1'b0;
    word_load   = 1'b0;
    if (state_q == IDLE) begin
      start_frame = cs_fall && armed_q;
    end else begin
      end_frame = cs_rise;
      // A CS rise in the same cycle as an SCLK edge swallows the edge.
      word_load = !cs_rise && sclk_fall && (bit_cnt_q == '0);
    end
    do_load   = start_frame || word_load;
    tx_accept = tx_valid && !buf_full_q;
  end

  always_ff @(posedge CLK_50) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_abort_q <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b0;
      armed_q       <= 1'b0;
      settle_q      <= '0;
    end else begin
      rx_valid_q    <= 1'b0;
      frame_abort_q <= 1'b0;
      tx_underrun_q <= 1'b0;

      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      if (settled && cs_s) begin
        armed_q <= 1'b1;
      end

      // Transmit buffer: a load always sees the buffer as it stood at the
      // start of this cycle, so a same-cycle accept cannot feed the load.
      if (do_load && buf_full_q) begin
        buf_full_q <= 1'b0;
      end else if (tx_accept) begin
        buf_q      <= tx_data;
        buf_full_q <= 1'b1;
      end

      if (do_load) begin
        tx_shift_q    <= buf_full_q ? buf_q : '0;
        tx_underrun_q <= !buf_full_q;
      end

      case (state_q)
        IDLE: begin
          if (start_frame) begin
            state_q    <= ACTIVE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
          end
        end
        ACTIVE: begin
          if (end_frame) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            if (bit_cnt_q != '0) begin
              frame_abort_q <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
              if (bit_cnt_q == LAST_BIT) begin
                rx_data_q  <= {rx_shift_q[DATA_W-2:0], mosi_s};
                rx_valid_q <= 1'b1;
                bit_cnt_q  <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
            // Mid-word falling edge advances the next MISO bit; the
            // word-boundary case is the load above.
            if (sclk_fall && (bit_cnt_q != '0)) begin
              tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      miso_q <= (state_q == ACTIVE) ? tx_shift_q[DATA_W-1] : 1'b0;
    end
  end

  assign SPI_outgoing = miso_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign tx_ready     = !buf_full_q;
  assign frame_active = (state_q == ACTIVE);
  assign frame_abort  = frame_abort_q;
  assign tx_underrun  = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// tb/tb_spi_slave_byte_if.sv - directed bench for spi_slave_byte_if
module tb_spi_slave_byte_if;

  logic       CLK_50;
  logic       rst;
  logic       CS;
  logic       SPI_CLK;
  logic       SPI_incoming;
  logic       SPI_outgoing;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       frame_active;
  logic       frame_abort;
  logic       tx_underrun;

  spi_slave_byte_if #(
    .DATA_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .CLK_50       (CLK_50),
    .rst          (rst),
    .CS           (CS),
    .SPI_CLK      (SPI_CLK),
    .SPI_incoming (SPI_incoming),
    .SPI_outgoing (SPI_outgoing),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .frame_active (frame_active),
    .frame_abort  (frame_abort),
    .tx_underrun  (tx_underrun)
  );

  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_rxv = 0;
  int n_und = 0;
  int n_abt = 0;
  int last_rxv_cyc = 0;
  int rise_cyc = 0;

  always @(posedge CLK_50) cyc <= cyc + 1;

  // Strobe counters, sampled mid-cycle.
  always @(negedge CLK_50) begin
    if (!rst) begin
      if (rx_valid) begin
        n_rxv = n_rxv + 1;
        last_rxv_cyc = cyc;
      end
      if (tx_underrun) n_und = n_und + 1;
      if (frame_abort) n_abt = n_abt + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK_50);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    int waited;
    waited = 0;
    while (!tx_ready && waited < 200) begin
      tick(1);
      waited = waited + 1;
    end
    check("push_ready_timeout", (waited < 200), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    check("push_tx_ready_low", tx_ready, 0);
  endtask

  task automatic start_frame();
    CS = 1'b0;
    tick(10);
  endtask

  // Shifts nbits MSB-first at CLK_50/10. MISO is read just before each
  // rising edge is driven. With end_frame set, the last SCLK fall and the
  // CS rise are driven together.
  task automatic xfer_bits(input logic [7:0] mosi, input int nbits, input bit end_frame,
                           output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      SPI_incoming = mosi[i];
      tick(5);
      miso[i] = SPI_outgoing;
      SPI_CLK = 1'b1;
      if (i == 8 - nbits) rise_cyc = cyc;
      tick(5);
      SPI_CLK = 1'b0;
      if (i == 8 - nbits && end_frame) CS = 1'b1;
    end
    tick(10);
  endtask

  typedef struct {
    bit         push;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_und;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] miso;
    logic [7:0] miso2;
    int rxv0, und0, abt0, lat;

    vecs[0] = '{push: 1'b1, tx: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C, exp_und: 0};
    vecs[1] = '{push: 1'b0, tx: 8'h00, mosi: 8'hFF, exp_miso: 8'h00, exp_rx: 8'hFF, exp_und: 1};
    vecs[2] = '{push: 1'b1, tx: 8'h96, mosi: 8'h69, exp_miso: 8'h96, exp_rx: 8'h69, exp_und: 0};
    vecs[3] = '{push: 1'b1, tx: 8'hFF, mosi: 8'h00, exp_miso: 8'hFF, exp_rx: 8'h00, exp_und: 0};
    vecs[4] = '{push: 1'b1, tx: 8'h01, mosi: 8'h80, exp_miso: 8'h01, exp_rx: 8'h80, exp_und: 0};

    rst = 1'b1;
    CS = 1'b1;
    SPI_CLK = 1'b0;
    SPI_incoming = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;

    // Reset state
    tick(3);
    check("rst_miso", SPI_outgoing, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_frame_active", frame_active, 0);
    check("rst_frame_abort", frame_abort, 0);
    check("rst_tx_underrun", tx_underrun, 0);
    rst = 1'b0;
    tick(20);
    check("idle_no_strobes", n_rxv + n_und + n_abt, 0);
    check("idle_tx_ready", tx_ready, 1);

    // Single-word frames from the table
    foreach (vecs[v]) begin
      if (vecs[v].push) push(vecs[v].tx);
      rxv0 = n_rxv;
      und0 = n_und;
      start_frame();
      check($sformatf("v%0d_frame_active", v), frame_active, 1);
      check($sformatf("v%0d_tx_ready_after_load", v), tx_ready, 1);
      xfer_bits(vecs[v].mosi, 8, 1'b1, miso);
      lat = last_rxv_cyc - rise_cyc;
      check($sformatf("v%0d_miso", v), miso, vecs[v].exp_miso);
      check($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx);
      check($sformatf("v%0d_rx_valid_count", v), n_rxv - rxv0, 1);
      check($sformatf("v%0d_rx_latency_3_4", v), (lat >= 3 && lat <= 4), 1);
      check($sformatf("v%0d_underruns", v), n_und - und0, vecs[v].exp_und);
      check($sformatf("v%0d_frame_idle", v), frame_active, 0);
      check($sformatf("v%0d_miso_idle", v), SPI_outgoing, 0);
      tick(5);
    end

    // Two-word frame, second word pushed while the first is on the wire
    push(8'h11);
    rxv0 = n_rxv;
    und0 = n_und;
    start_frame();
    fork
      xfer_bits(8'hC3, 8, 1'b0, miso);
      begin
        tick(20);
        push(8'h5A);
      end
    join
    check("w2_rx_first", rx_data, 8'hC3);
    xfer_bits(8'h7E, 8, 1'b1, miso2);
    check("w2_miso_first", miso, 8'h11);
    check("w2_miso_second", miso2, 8'h5A);
    check("w2_rx_second", rx_data, 8'h7E);
    check("w2_rx_valid_count", n_rxv - rxv0, 2);
    check("w2_no_underrun", n_und - und0, 0);
    tick(5);

    // Abort after 5 rising edges, then a clean frame
    rxv0 = n_rxv;
    abt0 = n_abt;
    start_frame();
    xfer_bits(8'hF0, 5, 1'b1, miso);
    check("abort_count", n_abt - abt0, 1);
    check("abort_no_rx_valid", n_rxv - rxv0, 0);
    check("abort_rx_data_kept", rx_data, 8'h7E);
    check("abort_frame_idle", frame_active, 0);
    push(8'h3C);
    start_frame();
    xfer_bits(8'h81, 8, 1'b1, miso);
    check("post_abort_rx", rx_data, 8'h81);
    check("post_abort_miso", miso, 8'h3C);
    check("post_abort_no_abort", n_abt - abt0, 1);
    tick(5);

    // Reset mid-frame with CS held low across release
    start_frame();
    xfer_bits(8'hAA, 3, 1'b0, miso);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(10);
    check("midrst_frame_active", frame_active, 0);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_tx_ready", tx_ready, 1);
    rxv0 = n_rxv;
    und0 = n_und;
    begin
      int fa_seen;
      fa_seen = 0;
      for (int i = 0; i < 8; i++) begin
        SPI_incoming = 1'b1;
        SPI_CLK = 1'b1;
        tick(5);
        if (frame_active) fa_seen = 1;
        SPI_CLK = 1'b0;
        tick(5);
        if (frame_active) fa_seen = 1;
      end
      check("midrst_sclk_ignored_active", fa_seen, 0);
    end
    check("midrst_no_rx_valid", n_rxv - rxv0, 0);
    check("midrst_no_underrun", n_und - und0, 0);
    CS = 1'b1;
    tick(10);
    start_frame();
    check("rearm_frame_active", frame_active, 1);
    xfer_bits(8'h42, 8, 1'b1, miso);
    check("rearm_rx", rx_data, 8'h42);
    check("rearm_rx_valid", n_rxv - rxv0, 1);
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_byte_if.md
Name: spi_slave_byte_if

Overview:
SPI mode-0 slave front end between the board SPI pins (CS, SPI_CLK, SPI_incoming, SPI_outgoing) and the fabric logic in the CLK_50 domain. It oversamples the SPI pins and deserialises MOSI into bytes, emitting each byte as a one-cycle strobe. It serialises bytes from a single-entry transmit buffer onto MISO. All logic is synchronous to CLK_50.

Parameters:
DATA_W, 8, bits per SPI word; MSB first.
SYNC_STAGES, 2, synchroniser depth for CS, SPI_CLK and SPI_incoming (minimum 2).

Ports:
CLK_50  input  1  system clock; the only clock in the block.
rst  input  1  synchronous, active-high reset.
CS  input  1  SPI chip select, active low, asynchronous pin.
SPI_CLK  input  1  SPI clock, asynchronous pin, idle low (CPOL=0).
SPI_incoming  input  1  MOSI pin.
SPI_outgoing  output  1  MISO, registered.
rx_data  output  DATA_W  last complete received word.
rx_valid  output  1  one-cycle strobe: rx_data updated.
tx_data  input  DATA_W  word to transmit.
tx_valid  input  1  tx_data offered.
tx_ready  output  1  transmit buffer empty; handshake completes when tx_valid&&tx_ready.
frame_active  output  1  high while a frame is in progress (ACTIVE state).
frame_abort  output  1  one-cycle strobe: CS deasserted mid-word.
tx_underrun  output  1  one-cycle strobe: shifter loaded while the buffer was empty.

Behaviour:
- Reset values: SPI_outgoing=0, rx_data=0, rx_valid=0, tx_ready=1, frame_active=0, frame_abort=0, tx_underrun=0. Buffer empty, bit_cnt=0, state IDLE, armed=0. CS synchroniser flops reset to 1; the other synchroniser flops reset to 0.
- Synchronise all three pins through SYNC_STAGES flops, giving cs_s, sclk_s and mosi_s. Edges are detected against a one-cycle-delayed copy. Pin-to-event latency is SYNC_STAGES+1 cycles.
- Supported SPI_CLK rate: at most CLK_50/8. Each SPI_CLK phase must last at least 4 CLK_50 cycles.
- armed: set once cs_s=1 has been seen for at least one cycle. The CS falling edge is honoured only when armed=1. A CS held low through reset release therefore starts no frame.
- State machine:
  - IDLE: on a cs_s falling edge with armed=1, go to ACTIVE. Clear bit_cnt and rx_shift, then perform a TX load.
  - ACTIVE: on a cs_s rising edge, go to IDLE. If bit_cnt!=0, pulse frame_abort and discard the partial rx word. The loaded TX word is lost and the buffer is not restored.
- frame_active equals (state==ACTIVE).
- sclk_s rising edge in ACTIVE (sample):
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}; bit_cnt increments.
  - When bit_cnt==DATA_W-1: rx_data <= the completed word, rx_valid=1 on the next cycle, bit_cnt wraps to 0.
- sclk_s falling edge in ACTIVE (shift):
  - If bit_cnt==0 (word boundary): TX load.
  - Otherwise: tx_shift <<= 1.
- TX load:
  - Buffer full: tx_shift <= buffer, buffer marked empty, tx_ready goes to 1 on the next cycle.
  - Buffer empty: tx_shift <= 0, pulse tx_underrun.
- SPI_outgoing <= frame_active ? tx_shift[DATA_W-1] : 0, registered.
- Transmit buffer:
  - Single entry. tx_valid&&tx_ready captures tx_data; tx_ready drops on the next cycle.
  - Accept and load in the same cycle: the load sees the pre-cycle (empty) buffer and underruns. The newly accepted word stays buffered for the next word. There is no bypass.
- SCLK edges while IDLE are ignored. Simultaneous CS rise and SCLK edge: CS wins and the edge is ignored.
- rx_valid has no backpressure. Each completed word overwrites rx_data.
- Reset mid-frame returns the block to reset values immediately. The next frame requires CS high, then low.

Decomposition:
- Package spi_pkg:
  - SPI_DATA_W default.
  - State enum {IDLE, ACTIVE}.
  - Bit-counter width function clog2(DATA_W).
- Sub-module sync_edge_detect (parameters SYNC_STAGES and RESET_VAL):
  - Outputs: synchronised level, rise strobe, fall strobe.
  - Instantiated for CS (RESET_VAL=1) and SPI_CLK.
  - SPI_incoming uses the same module with the strobes unused.

Test Plan:
1. Assert rst for 3 cycles with CS=1 -> every output at its reset value and tx_ready=1; no strobes for 20 cycles.
2. Push 0xA5, then run a frame with MOSI=0x3C at SPI_CLK=CLK_50/10 -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; exactly one rx_valid, 3–4 cycles after the 8th SCLK rise; tx_ready back to 1.
3. Push 0x11; during byte 1 of a 2-byte frame push 0x5A; MOSI=0xC3,0x7E -> MISO 0x11 then 0x5A; rx_valid twice with 0xC3, then 0x7E; no tx_underrun.
4. Run a frame with the buffer empty, MOSI=0xFF -> MISO all 0; one tx_underrun; rx_data=0xFF.
5. Raise CS after 5 SCLK rises -> frame_abort=1 for one cycle, no rx_valid. The next frame with MOSI=0x81 -> rx_data=0x81.
6. Assert rst mid-frame with CS low and release it with CS still low -> frame_active stays 0 and SCLK is ignored. Then CS high, low and MOSI=0x42 -> rx_data=0x42.
